// File: rtl/nes_controller_reader_pkg.sv
// ---------------------------------------------------------------------------
// nes_pkg
// Shared definitions for the NES controller reader.
//   - nesState_t : FSM state encoding used by nes_controller_reader
//   - BTN_*      : bit position of every button inside the 8-bit buttons word
//   - DEFAULT_*  : default timing for a 50 MHz system clock
//   - frameCycles: number of clk cycles one complete frame occupies
// ---------------------------------------------------------------------------
package nes_pkg;

   // 6 us half-phase and 60 Hz frame rate at 50 MHz
   localparam int DEFAULT_HALF_CYCLES = 300;
   localparam int DEFAULT_POLL_CYCLES = 833333;

   localparam int NUM_BUTTONS = 8;
   // The latch delivers the first bit, each clock pulse delivers one more
   localparam int NUM_PULSES  = NUM_BUTTONS - 1;

   // Button bit positions, in the order the controller shifts them out
   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LATCH    = 3'd1,
      PULSE_HI = 3'd2,
      PULSE_LO = 3'd3,
      DONE     = 3'd4
   } nesState_t;

   // Latch (two half-phases) + seven pulses (two half-phases each) + DONE
   function automatic int frameCycles(input int halfCycles);
      return (2 + 2 * NUM_PULSES) * halfCycles + 1;
   endfunction

endpackage

// File: rtl/nes_controller_reader_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous single-bit signal into the
// clk domain. Both flops reset to RESET_VALUE so the output does not glitch
// away from the idle level of the incoming line while reset is applied.
//
// Ports
//   clk     : destination clock
//   reset   : asynchronous, active-low reset
//   i_async : asynchronous input
//   o_sync  : synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // First flop may go metastable; the second gives it a full cycle to settle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= RESET_VALUE;
         r_sync <= RESET_VALUE;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/nes_controller_reader.sv
// ---------------------------------------------------------------------------
// nes_controller_reader
// Periodically polls an NES controller over its latch / clock / data lines
// and publishes the eight button states.
//
// A frame starts whenever the free-running poll counter is at zero and the
// FSM is idle. The latch is held for two half-phases, then seven clock
// pulses follow. The data line is sampled at the end of the latch (A) and
// at the end of every pulse-high phase (B .. Right); the line is active-low
// so the collected word is inverted before it is published.
//
// Parameters
//   HALF_CYCLES : clk cycles per latch/pulse half-phase
//   POLL_CYCLES : clk cycles between frame starts (must leave room for a
//                 whole frame plus one idle cycle)
//
// Ports
//   clk           : system clock, the only clock
//   reset         : asynchronous, active-low reset
//   NESinputData  : serial data from the controller (active-low, async)
//   latch         : controller latch strobe
//   pulse         : controller clock strobe
//   buttons       : pressed = 1; bit7 A .. bit0 Right
//   buttons_valid : one-cycle strobe when buttons is written
//   busy          : high while a frame is in progress
//
// Build option
//   NES_DEBOUNCE_EN : when defined, a frame result is only published if it
//                     equals the raw result of the previous frame.
// ---------------------------------------------------------------------------
module nes_controller_reader
   import nes_pkg::*;
#(
   parameter int HALF_CYCLES = DEFAULT_HALF_CYCLES,
   parameter int POLL_CYCLES = DEFAULT_POLL_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       NESinputData,
   output logic       latch,
   output logic       pulse,
   output logic [7:0] buttons,
   output logic       buttons_valid,
   output logic       busy
);

   localparam int TIMER_W = $clog2(2 * HALF_CYCLES);
   localparam int POLL_W  = $clog2(POLL_CYCLES);

   localparam logic [TIMER_W-1:0] LATCH_LAST = TIMER_W'(2 * HALF_CYCLES - 1);
   localparam logic [TIMER_W-1:0] HALF_LAST  = TIMER_W'(HALF_CYCLES - 1);
   localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
   localparam logic [2:0]         PULSE_LAST = 3'(NUM_PULSES - 1);

   // Reject timings where a frame could not finish before the next poll
   if (HALF_CYCLES < 1) begin : g_badHalf
      $error("nes_controller_reader: HALF_CYCLES must be at least 1");
   end
   if (POLL_CYCLES < frameCycles(HALF_CYCLES) + 1) begin : g_badPoll
      $error("nes_controller_reader: POLL_CYCLES must be >= 16*HALF_CYCLES+2");
   end

   nesState_t          r_state;
   nesState_t          w_nextState;
   logic [TIMER_W-1:0] r_timer;
   logic [POLL_W-1:0]  r_pollCount;
   logic [2:0]         r_pulseCount;
   logic [7:0]         r_shift;
   logic [7:0]         r_buttons;
   logic               r_valid;

   logic               w_dataSync;
   logic               w_latchDone;
   logic               w_hiDone;
   logic               w_loDone;
   logic               w_frameEnd;
   logic               w_sample;
   logic               w_commit;
   logic [7:0]         w_result;

   // The controller line idles high, so the synchronizer resets to 1
   sync_2ff #(
      .RESET_VALUE (1'b1)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (NESinputData),
      .o_sync  (w_dataSync)
   );

   // Poll counter runs regardless of the FSM so frame starts stay periodic
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pollCount <= '0;
      end else if (r_pollCount == POLL_LAST) begin
         r_pollCount <= '0;
      end else begin
         r_pollCount <= r_pollCount + POLL_W'(1);
      end
   end

   // End-of-phase markers shared by the FSM and the datapath
   assign w_latchDone = (r_state == LATCH)    && (r_timer == LATCH_LAST);
   assign w_hiDone    = (r_state == PULSE_HI) && (r_timer == HALF_LAST);
   assign w_loDone    = (r_state == PULSE_LO) && (r_timer == HALF_LAST);
   assign w_frameEnd  = w_loDone && (r_pulseCount == PULSE_LAST);
   assign w_sample    = w_latchDone || w_hiDone;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (r_pollCount == '0) begin
               w_nextState = LATCH;
            end
         end
         LATCH: begin
            if (w_latchDone) begin
               w_nextState = PULSE_HI;
            end
         end
         PULSE_HI: begin
            if (w_hiDone) begin
               w_nextState = PULSE_LO;
            end
         end
         PULSE_LO: begin
            if (w_frameEnd) begin
               w_nextState = DONE;
            end else if (w_loDone) begin
               w_nextState = PULSE_HI;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // FSM outputs are decoded from the state alone, so latch and pulse can
   // never overlap and all three drop the moment reset asserts
   always_comb begin
      latch = 1'b0;
      pulse = 1'b0;
      busy  = 1'b0;
      case (r_state)
         IDLE:     busy = 1'b0;
         LATCH:    begin latch = 1'b1; busy = 1'b1; end
         PULSE_HI: begin pulse = 1'b1; busy = 1'b1; end
         PULSE_LO: busy = 1'b1;
         DONE:     busy = 1'b1;
         default:  busy = 1'b0;
      endcase
   end

   // Phase timer restarts on every state change and rests at 0 when idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_timer <= '0;
      end else if ((r_state == IDLE) || (w_nextState != r_state)) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + TIMER_W'(1);
      end
   end

   // Counts completed pulse-low phases to know when the seventh one ends
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pulseCount <= '0;
      end else if (r_state == IDLE) begin
         r_pulseCount <= '0;
      end else if (w_loDone) begin
         r_pulseCount <= r_pulseCount + 3'd1;
      end
   end

   // A arrives first, so shifting left leaves it in bit 7 after eight samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift <= 8'hFF;
      end else if (w_sample) begin
         r_shift <= {r_shift[6:0], w_dataSync};
      end
   end

   assign w_result = ~r_shift;

`ifdef NES_DEBOUNCE_EN
   logic [7:0] r_prevRaw;

   // Remember every raw frame result, published or not, for the next compare
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prevRaw <= 8'h00;
      end else if (w_frameEnd) begin
         r_prevRaw <= w_result;
      end
   end

   assign w_commit = w_frameEnd && (w_result == r_prevRaw);
`else
   assign w_commit = w_frameEnd;
`endif

   // Written on entry to DONE so buttons and the strobe appear together
   // during the single DONE cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_buttons <= 8'h00;
         r_valid   <= 1'b0;
      end else begin
         r_valid <= w_commit;
         if (w_commit) begin
            r_buttons <= w_result;
         end
      end
   end

   assign buttons       = r_buttons;
   assign buttons_valid = r_valid;

endmodule

// File: doc/nes_controller_reader.md
NES_CONTROLLER_READER -- requirements
Module: nes_controller_reader

Interface
REQ-001 SHALL have parameter HALF_CYCLES, default 300, clk cycles per latch/pulse half-phase (6 us at 50 MHz).
REQ-002 SHALL have parameter POLL_CYCLES, default 833333, clk cycles between frame starts (60 Hz at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock (50 MHz domain); the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port NESinputData  input  1  serial data from controller, active-low, asynchronous to clk.
REQ-006 SHALL have port latch  output  1  controller latch strobe, active-high.
REQ-007 SHALL have port pulse  output  1  controller clock strobe, active-high.
REQ-008 SHALL have port buttons  output  8  pressed=1; bit7 A, bit6 B, bit5 Select, bit4 Start, bit3 Up, bit2 Down, bit1 Left, bit0 Right.
REQ-009 SHALL have port buttons_valid  output  1  one-cycle strobe when buttons is written.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-011 NESinputData SHALL pass through a 2-flop synchronizer; all samples use the synchronized value.
REQ-012 FSM states: IDLE, LATCH, PULSE_HI, PULSE_LO, DONE.
REQ-013 Free-running poll counter 0..POLL_CYCLES-1, wraps to 0; IDLE->LATCH when counter==0.
REQ-014 LATCH: latch=1 for 2*HALF_CYCLES cycles; on its last cycle sample bit7 (A); ->PULSE_HI.
REQ-015 PULSE_HI: pulse=1 for HALF_CYCLES cycles; sample next bit on its last cycle; ->PULSE_LO.
REQ-016 PULSE_LO: pulse=0 for HALF_CYCLES cycles; after 7th PULSE_LO ->DONE, else ->PULSE_HI.
REQ-017 Exactly 7 pulse highs per frame; samples fill bits 7 down to 0 in order.
REQ-018 DONE lasts 1 cycle: buttons <= ~shift register, buttons_valid=1, ->IDLE.
REQ-019 Frame length 16*HALF_CYCLES+1 cycles; POLL_CYCLES < 16*HALF_CYCLES+2 SHALL be a parameter error (elaboration assertion).
REQ-020 busy=1 in every state except IDLE; latch and pulse SHALL never be high together.
REQ-021 Controller absent (input held 1) SHALL yield buttons=8'h00 each frame.

Reset
REQ-022 reset low SHALL immediately force IDLE, latch=0, pulse=0, busy=0, buttons_valid=0, buttons=8'h00, counters=0, synchronizer flops=1.
REQ-023 Reset mid-frame SHALL abort the frame with no buttons_valid strobe.
REQ-024 First latch rise SHALL occur on the first clk edge after reset deasserts.

Configuration
REQ-025 Macro NES_DEBOUNCE_EN: when defined, buttons is written (with buttons_valid) only if the frame result equals the previous frame's raw result; otherwise no write, no strobe.
REQ-026 Without NES_DEBOUNCE_EN, every completed frame writes buttons and strobes buttons_valid.

Structure
REQ-027 Package nes_pkg SHALL hold the FSM state enum, button bit-index constants, and default HALF_CYCLES/POLL_CYCLES.
REQ-028 Synchronizer SHALL be sub-module sync_2ff (reset value parameterized, here 1).

Verification (HALF_CYCLES=4, POLL_CYCLES=100)
REQ-029 Release reset, model returns A+Start pressed -> latch high cycles 1-8, 7 pulses of 4 cycles, buttons=8'h90 with buttons_valid at cycle 65.
REQ-030 Input held 1 -> buttons=8'h00 and buttons_valid every 100 cycles; second latch rise at cycle 101.
REQ-031 Assert reset during 3rd pulse -> latch/pulse/busy 0 same cycle, no strobe, buttons=8'h00, frame restarts after release.
REQ-032 Model Right only (bit 0) -> buttons=8'h01; check pulse/latch never both high across frame.
REQ-033 NES_DEBOUNCE_EN: frames 8'h80, 8'h40, 8'h40 -> strobes only after third frame, buttons=8'h40; without macro three strobes.
